alarm_trigger: RTL and testbench

- Read side of the alarm-time path: compares the live clock time against the stored alarm time and raises the alarm.
- Sequences ring, snooze, dismiss and auto-timeout.
- Sits between the alarm-time setter / timekeeping counters and the buzzer/LED driver.
- All time fields are 8-bit binary (seconds 0-59, minutes 0-59, hours 0-23).

---
 rtl/alarm_pkg.sv | 23 ++
 rtl/alarm_time_compare.sv | 39 +++
 rtl/alarm_trigger.sv | 152 +++++++++++++++
 tb/tb_alarm_trigger.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared alarm-path types and time-field limits, also used by the alarm-time setter.
package alarm_pkg;

  localparam int unsigned TIME_W = 8;

  localparam logic [TIME_W-1:0] SEC_MAX = 8'd59;
  localparam logic [TIME_W-1:0] MIN_MAX = 8'd59;
  localparam logic [TIME_W-1:0] HR_MAX  = 8'd23;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StArmed   = 2'b01,
    StRinging = 2'b10,
    StSnoozed = 2'b11
  } alarm_state_e;

  function automatic logic time_valid(input logic [TIME_W-1:0] hours,
                                      input logic [TIME_W-1:0] minutes,
                                      input logic [TIME_W-1:0] seconds);
    return (hours <= HR_MAX) && (minutes <= MIN_MAX) && (seconds <= SEC_MAX);
  endfunction

endpackage

// File: rtl/alarm_time_compare.sv
// Three-field time equality with a TICK-qualified edge flag; emits one pulse per
// entry into the matching second.
module alarm_time_compare
  import alarm_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              tick_i,
  input  logic [TIME_W-1:0] seconds_i,
  input  logic [TIME_W-1:0] minutes_i,
  input  logic [TIME_W-1:0] hours_i,
  input  logic [TIME_W-1:0] alarm_seconds_i,
  input  logic [TIME_W-1:0] alarm_minutes_i,
  input  logic [TIME_W-1:0] alarm_hours_i,
  output logic              match_o
);

  logic equal;
  logic match_q;

  // An out-of-range alarm setting can never match, even against a bogus live time.
  always_comb begin
    equal = time_valid(alarm_hours_i, alarm_minutes_i, alarm_seconds_i) &&
            (seconds_i == alarm_seconds_i) &&
            (minutes_i == alarm_minutes_i) &&
            (hours_i   == alarm_hours_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      match_q <= 1'b0;
    end else if (tick_i) begin
      match_q <= equal;
    end
  end

  assign match_o = tick_i & equal & ~match_q;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm sequencer: ring, snooze, dismiss and auto-timeout on top of the time comparator.
// Define ALARM_BEEP_PATTERN_EN for a pulsed BUZZER (toggles per TICK while ringing).
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_SECONDS       = 300,
  parameter int unsigned RING_TIMEOUT_SECONDS = 60,
  parameter int unsigned MAX_SNOOZES          = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              TICK,
  input  logic [TIME_W-1:0] SECONDS,
  input  logic [TIME_W-1:0] MINUTES,
  input  logic [TIME_W-1:0] HOURS,
  input  logic [TIME_W-1:0] ALARM_SECONDS,
  input  logic [TIME_W-1:0] ALARM_MINUTES,
  input  logic [TIME_W-1:0] ALARM_HOURS,
  input  logic              ALARM_EN,
  input  logic              SNOOZE,
  input  logic              DISMISS,
  output logic              RINGING,
  output logic              SNOOZING,
  output logic              BUZZER,
  output logic [3:0]        SNOOZES_USED,
  output logic [1:0]        STATE
);

  localparam logic [15:0] SnzLoad   = 16'(SNOOZE_SECONDS);
  localparam logic [15:0] RingLimit = 16'(RING_TIMEOUT_SECONDS);
  localparam logic [3:0]  MaxSnz    = 4'(MAX_SNOOZES);

  alarm_state_e state_q, state_d;
  logic [15:0]  ring_cnt_q, ring_cnt_d;
  logic [15:0]  snz_cnt_q, snz_cnt_d;
  logic [3:0]   used_q, used_d;
  logic         ringing_q, snoozing_q;
  logic         buzzer_q, buzzer_d;
  logic         match;

  alarm_time_compare u_compare (
    .clk_i           (CLK),
    .reset_i         (RESET),
    .tick_i          (TICK),
    .seconds_i       (SECONDS),
    .minutes_i       (MINUTES),
    .hours_i         (HOURS),
    .alarm_seconds_i (ALARM_SECONDS),
    .alarm_minutes_i (ALARM_MINUTES),
    .alarm_hours_i   (ALARM_HOURS),
    .match_o         (match)
  );

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    used_d     = used_q;

    if (!ALARM_EN) begin
      state_d    = StIdle;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
      used_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArmed;

        StArmed: begin
          if (match) begin
            state_d    = StRinging;
            ring_cnt_d = '0;
            used_d     = '0;
          end
        end

        StRinging: begin
          if (DISMISS) begin
            state_d = StArmed;
            used_d  = '0;
          end else if (SNOOZE && (used_q < MaxSnz)) begin
            // A TICK in this cycle is deliberately not counted toward the timeout.
            state_d   = StSnoozed;
            snz_cnt_d = SnzLoad;
            used_d    = used_q + 4'd1;
          end else if (TICK) begin
            if (ring_cnt_q != 16'hFFFF) ring_cnt_d = ring_cnt_q + 16'd1;
            if (ring_cnt_d >= RingLimit) begin
              state_d = StArmed;
              used_d  = '0;
            end
          end
        end

        StSnoozed: begin
          if (DISMISS) begin
            state_d = StArmed;
            used_d  = '0;
          end else if (TICK) begin
            if (snz_cnt_q != 16'd0) snz_cnt_d = snz_cnt_q - 16'd1;
            if (snz_cnt_d == 16'd0) begin
              state_d    = StRinging;
              ring_cnt_d = '0;
            end
          end
        end
      endcase
    end
  end

`ifdef ALARM_BEEP_PATTERN_EN
  always_comb begin
    buzzer_d = 1'b0;
    if (state_d == StRinging) begin
      if (state_q != StRinging) buzzer_d = 1'b1;
      else if (TICK)            buzzer_d = ~buzzer_q;
      else                      buzzer_d = buzzer_q;
    end
  end
`else
  always_comb begin
    buzzer_d = (state_d == StRinging);
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      used_q     <= '0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      used_q     <= used_d;
      ringing_q  <= (state_d == StRinging);
      snoozing_q <= (state_d == StSnoozed);
      buzzer_q   <= buzzer_d;
    end
  end

  assign STATE        = state_q;
  assign RINGING      = ringing_q;
  assign SNOOZING     = snoozing_q;
  assign BUZZER       = buzzer_q;
  assign SNOOZES_USED = used_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with SNOOZE_SECONDS=5, RING_TIMEOUT_SECONDS=3, MAX_SNOOZES=2.
module tb_alarm_trigger;

`ifdef ALARM_BEEP_PATTERN_EN
  localparam bit Beep = 1'b1;
`else
  localparam bit Beep = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, tick, alarm_en, snooze, dismiss;
  logic [7:0] seconds, minutes, hours;
  logic [7:0] alarm_seconds, alarm_minutes, alarm_hours;
  logic       ringing, snoozing, buzzer;
  logic [3:0] snoozes_used;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  alarm_trigger #(
    .SNOOZE_SECONDS       (5),
    .RING_TIMEOUT_SECONDS (3),
    .MAX_SNOOZES          (2)
  ) dut (
    .CLK           (clk),
    .RESET         (reset),
    .TICK          (tick),
    .SECONDS       (seconds),
    .MINUTES       (minutes),
    .HOURS         (hours),
    .ALARM_SECONDS (alarm_seconds),
    .ALARM_MINUTES (alarm_minutes),
    .ALARM_HOURS   (alarm_hours),
    .ALARM_EN      (alarm_en),
    .SNOOZE        (snooze),
    .DISMISS       (dismiss),
    .RINGING       (ringing),
    .SNOOZING      (snoozing),
    .BUZZER        (buzzer),
    .SNOOZES_USED  (snoozes_used),
    .STATE         (state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hours   = h;
    minutes = m;
    seconds = s;
  endtask

  // RINGING/SNOOZING follow from the expected state.
  task automatic chk_st(input string tag, input logic [1:0] es, input logic [3:0] eu);
    logic [7:0] obs, exp;
    obs = {state, ringing, snoozing, snoozes_used};
    exp = {es, es == 2'b10, es == 2'b11, eu};
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_buz(input string tag, input logic eb);
    n_tests++;
    assert (buzzer === eb)
    else begin
      n_fail++;
      $error("FAIL %s: observed buzzer=%b expected %b", tag, buzzer, eb);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; alarm_en = 1'b1; snooze = 1'b0; dismiss = 1'b0;
    set_time(8'd7, 8'd29, 8'd59);
    alarm_hours = 8'd7; alarm_minutes = 8'd30; alarm_seconds = 8'd0;

    // Reset and arm
    cyc();
    chk_st("rst1", 2'b00, 4'd0);
    cyc();
    chk_st("rst2", 2'b00, 4'd0);
    chk_buz("rst_buz", 1'b0);
    reset = 1'b0;
    cyc();
    chk_st("armed", 2'b01, 4'd0);

    // Basic ring, then no re-trigger while time holds
    tick_cyc();
    chk_st("pre_match", 2'b01, 4'd0);
    set_time(8'd7, 8'd30, 8'd0);
    tick = 1'b1;
    #1;
    chk_st("tick_cycle", 2'b01, 4'd0);
    cyc();
    tick = 1'b0;
    chk_st("ring", 2'b10, 4'd0);
    chk_buz("ring_buz", 1'b1);
    dismiss = 1'b1; cyc(); dismiss = 1'b0;
    chk_st("dismiss", 2'b01, 4'd0);
    chk_buz("dismiss_buz", 1'b0);
    tick_cyc();
    tick_cyc();
    chk_st("no_retrig", 2'b01, 4'd0);

    // Snooze cycle
    set_time(8'd7, 8'd30, 8'd1); tick_cyc();
    set_time(8'd7, 8'd30, 8'd0); tick_cyc();
    chk_st("ring2", 2'b10, 4'd0);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk_st("snooze1", 2'b11, 4'd1);
    chk_buz("snooze_buz", 1'b0);
    set_time(8'd7, 8'd30, 8'd1); tick_cyc();
    set_time(8'd7, 8'd30, 8'd0); tick_cyc();
    chk_st("snz_match_ign", 2'b11, 4'd1);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk_st("snz_in_snz", 2'b11, 4'd1);
    tick_cyc();
    tick_cyc();
    chk_st("snz_4ticks", 2'b11, 4'd1);
    tick_cyc();
    chk_st("snz_expire", 2'b10, 4'd1);

    // Snooze limit; SNOOZE with TICK beats the timeout
    tick_cyc();
    tick_cyc();
    chk_st("ring_cnt2", 2'b10, 4'd1);
    tick = 1'b1; snooze = 1'b1; cyc(); tick = 1'b0; snooze = 1'b0;
    chk_st("tick_snooze", 2'b11, 4'd2);
    for (int i = 0; i < 5; i++) tick_cyc();
    chk_st("snz2_expire", 2'b10, 4'd2);
    tick_cyc();
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk_st("snz_limit", 2'b10, 4'd2);
    tick_cyc();
    chk_st("pre_timeout", 2'b10, 4'd2);
    tick_cyc();
    chk_st("timeout", 2'b01, 4'd0);
    chk_buz("timeout_buz", 1'b0);

    // Buzzer pattern, SNOOZE+DISMISS together
    set_time(8'd7, 8'd30, 8'd1); tick_cyc();
    set_time(8'd7, 8'd30, 8'd0); tick_cyc();
    chk_st("ring3", 2'b10, 4'd0);
    chk_buz("buz0", 1'b1);
    tick_cyc();
    chk_buz("buz1", !Beep);
    tick_cyc();
    chk_buz("buz2", 1'b1);
    snooze = 1'b1; dismiss = 1'b1; cyc(); snooze = 1'b0; dismiss = 1'b0;
    chk_st("snz_dis", 2'b01, 4'd0);
    chk_buz("snz_dis_buz", 1'b0);

    // ALARM_EN low while snoozed
    set_time(8'd7, 8'd30, 8'd1); tick_cyc();
    set_time(8'd7, 8'd30, 8'd0); tick_cyc();
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk_st("snooze_again", 2'b11, 4'd1);
    alarm_en = 1'b0; cyc();
    chk_st("en_low", 2'b00, 4'd0);
    chk_buz("en_low_buz", 1'b0);
    alarm_en = 1'b1; cyc();
    chk_st("rearm", 2'b01, 4'd0);

    // Out-of-range alarm never matches
    alarm_seconds = 8'd60;
    set_time(8'd7, 8'd30, 8'd59); tick_cyc();
    set_time(8'd7, 8'd30, 8'd60); tick_cyc();
    cyc();
    chk_st("oor_alarm", 2'b01, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
